// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;

  localparam int MAX_D_STREAK_DEF = 4;
  localparam int TIMEOUT_DEF      = 15;

  // Bits needed to hold the value max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int STREAK_W = cnt_w(MAX_D_STREAK_DEF);
  localparam int TCNT_W   = cnt_w(TIMEOUT_DEF - 1);

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch port, CPU data port and unified memory port of the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ack_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  logic              busy_o;
  logic              err_o;

  // master: the arbiter, which masters the memory bus and serves both CPU ports.
  modport master (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ack_i,
    output if_data_o, if_ack_o, dm_rdata_o, dm_ack_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, err_o
  );

  // slave: the CPU requesters and the memory around the arbiter.
  modport slave (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ack_i,
    input  if_data_o, if_ack_o, dm_rdata_o, dm_ack_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, err_o
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Fairness picker: data wins a tie unless it has used up its streak while fetch waits.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic streak_full,
  output gnt_t gnt
);

  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = GNT_I;
    if (dm_req && !(if_req && streak_full)) gnt = GNT_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one variable-latency memory,
// with a fetch-starvation limit and a per-access timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_if.master bus
);

  // Counters are never narrower than the default sizing.
  localparam int SW = (cnt_w(MAX_D_STREAK) > STREAK_W) ? cnt_w(MAX_D_STREAK) : STREAK_W;
  localparam int TW = (cnt_w(TIMEOUT - 1) > TCNT_W) ? cnt_w(TIMEOUT - 1) : TCNT_W;

  state_t        state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic          streak_full;
  gnt_t          pick;

  assign streak_full = (streak == SW'(MAX_D_STREAK));

  mem_arb_pick u_pick (
    .if_req      (bus.if_req_i),
    .dm_req      (bus.dm_req_i),
    .streak_full (streak_full),
    .gnt         (pick)
  );

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the read-data outputs are plain registers, not storage, so they reset too.
      state           <= IDLE;
      streak          <= '0;
      tcnt            <= '0;
      bus.if_data_o   <= '0;
      bus.if_ack_o    <= 1'b0;
      bus.dm_rdata_o  <= '0;
      bus.dm_ack_o    <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.busy_o      <= 1'b0;
      bus.err_o       <= 1'b0;
    end else begin
      bus.if_ack_o <= 1'b0;
      bus.dm_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req_i || bus.dm_req_i) begin
            bus.mem_req_o <= 1'b1;
            bus.busy_o    <= 1'b1;
            tcnt          <= '0;
            if (pick == GNT_I) begin
              bus.mem_we_o    <= 1'b0;
              bus.mem_addr_o  <= bus.if_addr_i;
              bus.mem_wdata_o <= '0;
              streak          <= '0;
              state           <= BUSY_I;
            end else begin
              bus.mem_we_o    <= bus.dm_we_i;
              bus.mem_addr_o  <= bus.dm_addr_i;
              bus.mem_wdata_o <= bus.dm_wdata_i;
              // The streak only grows while a fetch is actually being held off.
              if (!bus.if_req_i)     streak <= '0;
              else if (!streak_full) streak <= streak + 1'b1;
              state <= BUSY_D;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          tcnt <= tcnt + 1'b1;
          if (bus.mem_ack_i || tcnt == TW'(TIMEOUT - 1)) begin
            // An abort returns zero read data and latches the sticky error.
            if (!bus.mem_ack_i) bus.err_o <= 1'b1;
            if (state == BUSY_I) begin
              bus.if_data_o <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
              bus.if_ack_o  <= 1'b1;
            end else begin
              if (!bus.mem_we_o) bus.dm_rdata_o <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
              bus.dm_ack_o <= 1'b1;
            end
            bus.mem_req_o <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          tcnt       <= '0;
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
